// File: rtl/frame_hold_timer_if.sv
// rtl/frame_hold_timer_if.sv - control/status bundle between capture logic and frame_hold_timer
interface frame_hold_timer_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 8
);
  logic [9:0]           y_pixel;
  logic [NCH-1:0]       trig;
  logic [NCH-1:0]       cancel;
  logic [NCH*CNT_W-1:0] hold_len;
  logic [NCH-1:0]       hold_active;
  logic [NCH-1:0]       hold_done;
  logic                 any_active;
  logic                 frame_start;

  modport master (
    output y_pixel, trig, cancel, hold_len,
    input  hold_active, hold_done, any_active, frame_start
  );

  modport slave (
    input  y_pixel, trig, cancel, hold_len,
    output hold_active, hold_done, any_active, frame_start
  );
endinterface

// File: rtl/frame_hold_timer.sv
// rtl/frame_hold_timer.sv - per-channel hold outputs aligned to whole visible frames
module frame_hold_timer #(
  parameter int NCH       = 2,
  parameter int CNT_W     = 8,
  parameter int V_VISIBLE = 480,
  parameter int RETRIGGER = 0
) (
  input logic              vga_pclk,
  input logic              reset,
  frame_hold_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  localparam logic [9:0]       V_VIS = 10'(V_VISIBLE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic           vis;
  logic           vis_d;
  logic           frame_start;
  logic           frame_end;
  logic [NCH-1:0] active_q;
  logic [NCH-1:0] done_q;

  assign vis         = bus.y_pixel < V_VIS;
  assign frame_start = vis & ~vis_d;
  assign frame_end   = ~vis & vis_d;

  // vis_d resets high so a reset released mid-frame cannot fake a frame start
  always_ff @(posedge vga_pclk) begin
    if (reset) vis_d <= 1'b1;
    else       vis_d <= vis;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_in;
    logic [CNT_W-1:0] len_eff;
    logic             act_r;
    logic             done_r;

    assign len_in  = bus.hold_len[i*CNT_W +: CNT_W];
    assign len_eff = (len_in == '0) ? ONE : len_in;

    always_ff @(posedge vga_pclk) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        len_q  <= '0;
        act_r  <= 1'b0;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        if (bus.cancel[i]) begin
          state <= IDLE;
          cnt   <= '0;
          act_r <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (bus.trig[i]) begin
                state <= ARMED;
                len_q <= len_eff;
              end
            end
            ARMED: begin
              if (frame_start) begin
                state <= HOLD;
                act_r <= 1'b1;
                cnt   <= ONE;
              end
            end
            HOLD: begin
              if (RETRIGGER != 0 && bus.trig[i]) begin
                cnt   <= '0;
                len_q <= len_eff;
              end else if (frame_end && cnt == len_q) begin
                // release in blanking; a coincident trig re-arms for the next frame
                act_r  <= 1'b0;
                done_r <= 1'b1;
                cnt    <= '0;
                if (bus.trig[i]) begin
                  state <= ARMED;
                  len_q <= len_eff;
                end else begin
                  state <= IDLE;
                end
              end else if (frame_start && cnt < len_q) begin
                cnt <= cnt + ONE;
              end
            end
            default: begin
              state <= IDLE;
              act_r <= 1'b0;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign active_q[i] = act_r;
    assign done_q[i]   = done_r;
  end

  assign bus.hold_active = active_q;
  assign bus.hold_done   = done_q;
  assign bus.any_active  = |active_q;
  assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_frame_hold_timer.sv
// tb/tb_frame_hold_timer.sv - randomized and directed bench against a frame-level reference model
module tb_frame_hold_timer;
  localparam int NCH   = 2;
  localparam int CNT_W = 8;
  localparam int VV    = 480;
  localparam int LINES = 525;
  localparam int CPL   = 4;
  localparam int FRAME = LINES * CPL;

  logic                 vga_pclk = 1'b0;
  logic                 reset;
  logic [9:0]           y;
  logic [NCH-1:0]       trig;
  logic [NCH-1:0]       cancel;
  logic [NCH*CNT_W-1:0] hold_len;

  always #5 vga_pclk = ~vga_pclk;

  frame_hold_timer_if #(.NCH(NCH), .CNT_W(CNT_W)) bus0 ();
  frame_hold_timer_if #(.NCH(NCH), .CNT_W(CNT_W)) bus1 ();

  assign bus0.y_pixel  = y;
  assign bus0.trig     = trig;
  assign bus0.cancel   = cancel;
  assign bus0.hold_len = hold_len;
  assign bus1.y_pixel  = y;
  assign bus1.trig     = trig;
  assign bus1.cancel   = cancel;
  assign bus1.hold_len = hold_len;

  frame_hold_timer #(.NCH(NCH), .CNT_W(CNT_W), .V_VISIBLE(VV), .RETRIGGER(0)) u_dut0 (
    .vga_pclk(vga_pclk), .reset(reset), .bus(bus0.slave));
  frame_hold_timer #(.NCH(NCH), .CNT_W(CNT_W), .V_VISIBLE(VV), .RETRIGGER(1)) u_dut1 (
    .vga_pclk(vga_pclk), .reset(reset), .bus(bus1.slave));

  int checks   = 0;
  int failures = 0;

  // model: frames_left counts remaining frame ends before release
  bit m_armed [2][NCH];
  bit m_hold  [2][NCH];
  bit m_done  [2][NCH];
  int m_left  [2][NCH];
  int m_len   [2][NCH];
  bit m_vd;
  bit started = 0;

  int held  [2][NCH];
  int dones [2][NCH];
  int fs_seen;
  int line = 300;
  int sub  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t line=%0d", tag, got, exp, $time, line);
    end
  endtask

  task automatic clear_tally();
    for (int v = 0; v < 2; v++)
      for (int c = 0; c < NCH; c++) begin
        held[v][c]  = 0;
        dones[v][c] = 0;
      end
    fs_seen = 0;
  endtask

  task automatic tick();
    bit vis, fs, fe;
    bit [NCH-1:0] eh0, ed0, eh1, ed1;
    #1;
    vis = (line < VV);
    fs  = vis && !m_vd;
    fe  = !vis && m_vd;
    if (started) begin
      check("frame_start0", 32'(bus0.frame_start), 32'(fs));
      check("frame_start1", 32'(bus1.frame_start), 32'(fs));
    end
    if (fs) fs_seen++;
    for (int v = 0; v < 2; v++) begin
      for (int c = 0; c < NCH; c++) begin
        int L;
        L = int'(hold_len[c*CNT_W +: CNT_W]);
        if (L == 0) L = 1;
        m_done[v][c] = 0;
        if (reset || cancel[c]) begin
          m_armed[v][c] = 0;
          m_hold[v][c]  = 0;
          m_left[v][c]  = 0;
        end else if (m_hold[v][c]) begin
          if (v == 1 && trig[c]) begin
            m_left[v][c] = L + (vis ? 1 : 0);
          end else if (fe) begin
            m_left[v][c]--;
            if (m_left[v][c] == 0) begin
              m_hold[v][c] = 0;
              m_done[v][c] = 1;
              if (trig[c]) begin
                m_armed[v][c] = 1;
                m_len[v][c]   = L;
              end
            end
          end
        end else if (m_armed[v][c]) begin
          if (fs) begin
            m_armed[v][c] = 0;
            m_hold[v][c]  = 1;
            m_left[v][c]  = m_len[v][c];
          end
        end else if (trig[c]) begin
          m_armed[v][c] = 1;
          m_len[v][c]   = L;
        end
      end
    end
    m_vd = reset ? 1'b1 : vis;
    @(posedge vga_pclk);
    #1;
    started = 1;
    for (int c = 0; c < NCH; c++) begin
      eh0[c] = m_hold[0][c];
      ed0[c] = m_done[0][c];
      eh1[c] = m_hold[1][c];
      ed1[c] = m_done[1][c];
      if (bus0.hold_active[c]) held[0][c]++;
      if (bus1.hold_active[c]) held[1][c]++;
      if (bus0.hold_done[c]) dones[0][c]++;
      if (bus1.hold_done[c]) dones[1][c]++;
    end
    check("outputs0", 32'({bus0.any_active, bus0.hold_done, bus0.hold_active}), 32'({|eh0, ed0, eh0}));
    check("outputs1", 32'({bus1.any_active, bus1.hold_done, bus1.hold_active}), 32'({|eh1, ed1, eh1}));
    sub++;
    if (sub == CPL) begin
      sub = 0;
      line = (line == LINES - 1) ? 0 : line + 1;
    end
    y = 10'(line);
    if (failures >= 50) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  task automatic wait_line(input int target);
    int n = 0;
    while (!(line == target && sub == 0) && n < FRAME + 10) begin
      tick();
      n++;
    end
    check("wait_line", 32'(line == target && sub == 0), 32'd1);
  endtask

  task automatic pulse(input logic [NCH-1:0] t, input logic [NCH-1:0] c);
    trig   = t;
    cancel = c;
    tick();
    trig   = '0;
    cancel = '0;
  endtask

  task automatic set_len(input int l0, input int l1);
    hold_len = {CNT_W'(l1), CNT_W'(l0)};
  endtask

  initial begin
    reset    = 1'b1;
    trig     = '0;
    cancel   = '0;
    hold_len = '0;
    y        = 10'(line);
    m_vd     = 1'b1;
    for (int v = 0; v < 2; v++)
      for (int c = 0; c < NCH; c++) begin
        m_armed[v][c] = 0;
        m_hold[v][c]  = 0;
        m_left[v][c]  = 0;
        m_len[v][c]   = 1;
      end
    repeat (3) tick();
    reset = 1'b0;
    clear_tally();
    wait_line(479);
    check("no_fs_after_reset", 32'(fs_seen), 32'd0);

    // basic three-frame hold
    wait_line(100);
    set_len(3, 0);
    clear_tally();
    pulse(2'b01, 2'b00);
    run_frames(4);
    check("t1_held", 32'(held[0][0]), 32'(2 * FRAME + VV * CPL));
    check("t1_done", 32'(dones[0][0]), 32'd1);
    check("t1_held_r1", 32'(held[1][0]), 32'(2 * FRAME + VV * CPL));

    // zero length acts as one frame
    wait_line(200);
    set_len(0, 0);
    clear_tally();
    pulse(2'b10, 2'b00);
    run_frames(2);
    check("t2_held", 32'(held[0][1]), 32'(VV * CPL));
    check("t2_done", 32'(dones[0][1]), 32'd1);

    // retrigger in the second held frame
    wait_line(50);
    set_len(2, 0);
    clear_tally();
    pulse(2'b01, 2'b00);
    run_frames(2);
    pulse(2'b01, 2'b00);
    run_frames(4);
    check("t3_held_r1", 32'(held[1][0]), 32'(3 * FRAME + VV * CPL));
    check("t3_done_r1", 32'(dones[1][0]), 32'd1);
    check("t3_held_r0", 32'(held[0][0]), 32'(FRAME + VV * CPL));
    check("t3_done_r0", 32'(dones[0][0]), 32'd1);

    // cancel mid-hold, then re-arm
    wait_line(60);
    set_len(0, 5);
    clear_tally();
    pulse(2'b10, 2'b00);
    run_frames(2);
    pulse(2'b00, 2'b10);
    check("t4_cancel_low", 32'(bus0.hold_active[1]), 32'd0);
    run_frames(1);
    check("t4_no_done0", 32'(dones[0][1]), 32'd0);
    check("t4_no_done1", 32'(dones[1][1]), 32'd0);
    set_len(0, 1);
    clear_tally();
    pulse(2'b10, 2'b00);
    run_frames(2);
    check("t4_rearm_held", 32'(held[0][1]), 32'(VV * CPL));
    check("t4_rearm_done", 32'(dones[0][1]), 32'd1);

    // reset during hold, released mid-visible
    set_len(4, 0);
    pulse(2'b01, 2'b00);
    run_frames(2);
    wait_line(300);
    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    check("t5_outputs_zero", 32'({bus0.any_active, bus0.hold_done, bus0.hold_active}), 32'd0);
    clear_tally();
    wait_line(479);
    check("t5_no_fs", 32'(fs_seen), 32'd0);
    clear_tally();
    run_frames(1);
    check("t5_one_fs", 32'(fs_seen), 32'd1);

    // independent channels; trig+cancel together
    set_len(1, 4);
    wait_line(100);
    clear_tally();
    pulse(2'b01, 2'b00);
    run_frames(1);
    pulse(2'b10, 2'b00);
    run_frames(1);
    pulse(2'b01, 2'b01);
    run_frames(4);
    check("t6_ch0_held", 32'(held[0][0]), 32'(VV * CPL));
    check("t6_ch0_done", 32'(dones[0][0]), 32'd1);
    check("t6_ch1_held", 32'(held[0][1]), 32'(3 * FRAME + VV * CPL));
    check("t6_ch1_done", 32'(dones[0][1]), 32'd1);

    // random traffic against the model
    repeat (5 * FRAME) begin
      for (int c = 0; c < NCH; c++) begin
        trig[c]   = ($urandom_range(0, 1499) == 0);
        cancel[c] = ($urandom_range(0, 9999) == 0);
        hold_len[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
      end
      tick();
    end
    trig   = '0;
    cancel = '0;
    run_frames(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
